// File: rtl/coin_request_collector.sv
// Coin/selection accumulator that feeds one aggregated request to vendingMachine.
// It holds the request until the machine reports ON, then waits for it to return to OFF.
module coin_request_collector #(
  parameter int MAX_COUNT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coinValid,
  input  logic [1:0]  coinType,
  input  logic        selValid,
  input  logic [1:0]  selType,
  input  logic [2:0]  selNumber,
  input  logic        selForce,
  input  logic        confirm,
  input  logic        cancel,
  input  logic [1:0]  serviceTypeIn,
  output logic [5:0]  reqCoinA,
  output logic [5:0]  reqCoinB,
  output logic [5:0]  reqCoinC,
  output logic [5:0]  reqCoinD,
  output logic [1:0]  reqItemType,
  output logic [2:0]  reqItemNumber,
  output logic        reqForce,
  output logic        coinReject,
  output logic        refundValid,
  output logic [5:0]  refundA,
  output logic [5:0]  refundB,
  output logic [5:0]  refundC,
  output logic [5:0]  refundD,
  output logic [12:0] totalValue,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [5:0] MAX_CNT = 6'(MAX_COUNT);
  localparam logic [1:0] SVC_OFF = 2'b00;
  localparam logic [1:0] SVC_ON  = 2'b01;

  state_t          state_q, state_d;
  logic [3:0][5:0] cnt_q, cnt_d;
  logic [1:0]      sel_type_q, sel_type_d;
  logic [2:0]      sel_number_q, sel_number_d;
  logic            sel_force_q, sel_force_d;
  logic [3:0][5:0] req_coin_q, req_coin_d;
  logic [1:0]      req_item_type_q, req_item_type_d;
  logic [2:0]      req_item_number_q, req_item_number_d;
  logic            req_force_q, req_force_d;
  logic            coin_reject_q, coin_reject_d;
  logic            refund_valid_q, refund_valid_d;
  logic [3:0][5:0] refund_q, refund_d;

  logic            coin_ok;
  logic [3:0][5:0] cnt_inc;
  logic [1:0]      sel_type_new;
  logic [2:0]      sel_number_new;
  logic            sel_force_new;

  // Same-cycle coin and selection are folded in before cancel/confirm look at them.
  always_comb begin
    coin_ok = coinValid && (cnt_q[coinType] < MAX_CNT);
    cnt_inc = cnt_q;
    if (coin_ok) begin
      cnt_inc[coinType] = cnt_q[coinType] + 6'd1;
    end
    sel_type_new   = selValid ? selType   : sel_type_q;
    sel_number_new = selValid ? selNumber : sel_number_q;
    sel_force_new  = selValid ? selForce  : sel_force_q;
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    sel_type_d        = sel_type_q;
    sel_number_d      = sel_number_q;
    sel_force_d       = sel_force_q;
    req_coin_d        = req_coin_q;
    req_item_type_d   = req_item_type_q;
    req_item_number_d = req_item_number_q;
    req_force_d       = req_force_q;
    coin_reject_d     = 1'b0;
    refund_valid_d    = 1'b0;
    refund_d          = refund_q;

    case (state_q)
      IDLE: begin
        coin_reject_d = coinValid && !coin_ok;
        cnt_d         = cnt_inc;
        sel_type_d    = sel_type_new;
        sel_number_d  = sel_number_new;
        sel_force_d   = sel_force_new;
        if (cancel) begin
          refund_d       = cnt_inc;
          refund_valid_d = 1'b1;
          cnt_d          = '0;
        end else if (confirm && (sel_number_new != 3'd0)) begin
          req_coin_d        = cnt_inc;
          req_item_type_d   = sel_type_new;
          req_item_number_d = sel_number_new;
          req_force_d       = sel_force_new;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        coin_reject_d = coinValid;
        // The machine latches the request on the same edge it reports ON.
        if (serviceTypeIn == SVC_ON) begin
          req_coin_d        = '0;
          req_item_type_d   = '0;
          req_item_number_d = '0;
          req_force_d       = 1'b0;
          cnt_d             = '0;
          sel_type_d        = '0;
          sel_number_d      = '0;
          sel_force_d       = 1'b0;
          state_d           = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        coin_reject_d = coinValid;
        if (serviceTypeIn == SVC_OFF) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      sel_type_q        <= '0;
      sel_number_q      <= '0;
      sel_force_q       <= 1'b0;
      req_coin_q        <= '0;
      req_item_type_q   <= '0;
      req_item_number_q <= '0;
      req_force_q       <= 1'b0;
      coin_reject_q     <= 1'b0;
      refund_valid_q    <= 1'b0;
      refund_q          <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      sel_type_q        <= sel_type_d;
      sel_number_q      <= sel_number_d;
      sel_force_q       <= sel_force_d;
      req_coin_q        <= req_coin_d;
      req_item_type_q   <= req_item_type_d;
      req_item_number_q <= req_item_number_d;
      req_force_q       <= req_force_d;
      coin_reject_q     <= coin_reject_d;
      refund_valid_q    <= refund_valid_d;
      refund_q          <= refund_d;
    end
  end

  assign reqCoinA      = req_coin_q[0];
  assign reqCoinB      = req_coin_q[1];
  assign reqCoinC      = req_coin_q[2];
  assign reqCoinD      = req_coin_q[3];
  assign reqItemType   = req_item_type_q;
  assign reqItemNumber = req_item_number_q;
  assign reqForce      = req_force_q;
  assign coinReject    = coin_reject_q;
  assign refundValid   = refund_valid_q;
  assign refundA       = refund_q[0];
  assign refundB       = refund_q[1];
  assign refundC       = refund_q[2];
  assign refundD       = refund_q[3];

  // Widened before multiplying so 63*66 fits without overflow.
  assign totalValue = 13'(cnt_q[0]) * 13'd50 + 13'(cnt_q[1]) * 13'd10
                    + 13'(cnt_q[2]) * 13'd5  + 13'(cnt_q[3]);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_coin_request_collector.sv
// Randomized bench for coin_request_collector, checked against a behavioural model
// that tracks coin counts, the latched selection and the transaction phase.
module tb_coin_request_collector;

  localparam int MAX_COUNT = 63;
  localparam int COIN_VALUE[4] = '{50, 10, 5, 1};

  logic        clk = 1'b0;
  logic        reset, coinValid, selValid, selForce, confirm, cancel;
  logic [1:0]  coinType, selType, serviceTypeIn;
  logic [2:0]  selNumber;
  logic [5:0]  reqCoinA, reqCoinB, reqCoinC, reqCoinD;
  logic [1:0]  reqItemType;
  logic [2:0]  reqItemNumber;
  logic        reqForce, coinReject, refundValid, busy;
  logic [5:0]  refundA, refundB, refundC, refundD;
  logic [12:0] totalValue;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 = waiting for input, 1 = request presented, 2 = served, waiting for OFF
  int mPhase;
  int mCount[4];
  int mSelType, mSelNumber, mSelForce;
  int mReq[4];
  int mReqType, mReqNumber, mReqForce;
  int mReject, mRefundValid;
  int mRefund[4];

  always #5 clk = ~clk;

  coin_request_collector #(.MAX_COUNT(MAX_COUNT)) dut (
    .clk(clk), .reset(reset), .coinValid(coinValid), .coinType(coinType),
    .selValid(selValid), .selType(selType), .selNumber(selNumber), .selForce(selForce),
    .confirm(confirm), .cancel(cancel), .serviceTypeIn(serviceTypeIn),
    .reqCoinA(reqCoinA), .reqCoinB(reqCoinB), .reqCoinC(reqCoinC), .reqCoinD(reqCoinD),
    .reqItemType(reqItemType), .reqItemNumber(reqItemNumber), .reqForce(reqForce),
    .coinReject(coinReject), .refundValid(refundValid),
    .refundA(refundA), .refundB(refundB), .refundC(refundC), .refundD(refundD),
    .totalValue(totalValue), .busy(busy)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelClear();
    mPhase = 0;
    mSelType = 0; mSelNumber = 0; mSelForce = 0;
    mReqType = 0; mReqNumber = 0; mReqForce = 0;
    mReject = 0; mRefundValid = 0;
    for (int i = 0; i < 4; i++) begin
      mCount[i] = 0; mReq[i] = 0; mRefund[i] = 0;
    end
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    mReject = 0;
    mRefundValid = 0;
    if (reset) begin
      modelClear();
      return;
    end
    if (mPhase == 0) begin
      if (coinValid) begin
        if (mCount[coinType] < MAX_COUNT) mCount[coinType]++;
        else mReject = 1;
      end
      if (selValid) begin
        mSelType = selType; mSelNumber = selNumber; mSelForce = selForce;
      end
      if (cancel) begin
        for (int i = 0; i < 4; i++) begin
          mRefund[i] = mCount[i];
          mCount[i] = 0;
        end
        mRefundValid = 1;
      end else if (confirm && mSelNumber != 0) begin
        for (int i = 0; i < 4; i++) mReq[i] = mCount[i];
        mReqType = mSelType; mReqNumber = mSelNumber; mReqForce = mSelForce;
        mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (coinValid) mReject = 1;
      if (serviceTypeIn == 2'b01) begin
        for (int i = 0; i < 4; i++) begin
          mReq[i] = 0; mCount[i] = 0;
        end
        mReqType = 0; mReqNumber = 0; mReqForce = 0;
        mSelType = 0; mSelNumber = 0; mSelForce = 0;
        mPhase = 2;
      end
    end else begin
      if (coinValid) mReject = 1;
      if (serviceTypeIn == 2'b00) mPhase = 0;
    end
  endtask

  task automatic compareAll();
    int total;
    total = 0;
    for (int i = 0; i < 4; i++) total += COIN_VALUE[i] * mCount[i];
    checkOutput("busy", busy, (mPhase != 0) ? 1 : 0);
    checkOutput("totalValue", totalValue, total);
    checkOutput("reqCoinA", reqCoinA, mReq[0]);
    checkOutput("reqCoinB", reqCoinB, mReq[1]);
    checkOutput("reqCoinC", reqCoinC, mReq[2]);
    checkOutput("reqCoinD", reqCoinD, mReq[3]);
    checkOutput("reqItemType", reqItemType, mReqType);
    checkOutput("reqItemNumber", reqItemNumber, mReqNumber);
    checkOutput("reqForce", reqForce, mReqForce);
    checkOutput("coinReject", coinReject, mReject);
    checkOutput("refundValid", refundValid, mRefundValid);
    checkOutput("refundA", refundA, mRefund[0]);
    checkOutput("refundB", refundB, mRefund[1]);
    checkOutput("refundC", refundC, mRefund[2]);
    checkOutput("refundD", refundD, mRefund[3]);
  endtask

  task automatic applyStimulus(input logic rst, input logic cv, input logic [1:0] ct,
                               input logic sv, input logic [1:0] st, input logic [2:0] sn,
                               input logic sf, input logic cf, input logic cn,
                               input logic [1:0] svc);
    reset = rst; coinValid = cv; coinType = ct;
    selValid = sv; selType = st; selNumber = sn; selForce = sf;
    confirm = cf; cancel = cn; serviceTypeIn = svc;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic insertCoin(input logic [1:0] ct, input logic [1:0] svc);
    applyStimulus(1'b0, 1'b1, ct, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, svc);
  endtask

  task automatic idleCycle(input logic [1:0] svc);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, svc);
  endtask

  task automatic selectItem(input logic [1:0] st, input logic [2:0] sn, input logic sf);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, st, sn, sf, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic confirmReq(input logic [1:0] svc);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, svc);
  endtask

  initial begin
    modelClear();
    #2;
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_total", totalValue, 0);

    // A,A,B,D,D
    insertCoin(2'd0, 2'b00); insertCoin(2'd0, 2'b00); insertCoin(2'd1, 2'b00);
    insertCoin(2'd3, 2'b00); insertCoin(2'd3, 2'b00);
    checkOutput("tp1_total", totalValue, 112);
    checkOutput("tp1_reqA", reqCoinA, 0);

    selectItem(2'd1, 3'd3, 1'b0);
    confirmReq(2'b01);
    checkOutput("tp2_busy", busy, 1);
    checkOutput("tp2_reqA", reqCoinA, 2);
    checkOutput("tp2_reqB", reqCoinB, 1);
    checkOutput("tp2_reqD", reqCoinD, 2);
    checkOutput("tp2_num", reqItemNumber, 3);
    idleCycle(2'b01);
    checkOutput("tp2_served_num", reqItemNumber, 0);
    checkOutput("tp2_served_busy", busy, 1);
    idleCycle(2'b10);
    checkOutput("tp2_wait_busy", busy, 1);
    idleCycle(2'b00);
    checkOutput("tp2_idle_busy", busy, 0);

    // Request held while the machine stays BUSY
    selectItem(2'd2, 3'd2, 1'b1);
    confirmReq(2'b10);
    for (int i = 0; i < 4; i++) begin
      idleCycle(2'b10);
      checkOutput("tp3_hold_num", reqItemNumber, 2);
      checkOutput("tp3_hold_force", reqForce, 1);
    end
    idleCycle(2'b01);
    checkOutput("tp3_served_num", reqItemNumber, 0);
    idleCycle(2'b00);

    // Cap on type C
    for (int i = 0; i < 64; i++) begin
      insertCoin(2'd2, 2'b00);
      checkOutput("tp4_reject", coinReject, (i == 63) ? 1 : 0);
    end
    checkOutput("tp4_total", totalValue, 315);
    selectItem(2'd0, 3'd1, 1'b0);
    confirmReq(2'b00);
    idleCycle(2'b01);
    insertCoin(2'd3, 2'b10);
    checkOutput("tp4_wait_reject", coinReject, 1);
    checkOutput("tp4_wait_total", totalValue, 0);
    idleCycle(2'b00);

    // cancel + confirm + coin in one cycle
    selectItem(2'd3, 3'd4, 1'b0);
    insertCoin(2'd1, 2'b00); insertCoin(2'd1, 2'b00);
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1, 2'b00);
    checkOutput("tp5_refundB", refundB, 2);
    checkOutput("tp5_refundD", refundD, 1);
    checkOutput("tp5_refundValid", refundValid, 1);
    checkOutput("tp5_busy", busy, 0);
    checkOutput("tp5_total", totalValue, 0);
    idleCycle(2'b00);
    checkOutput("tp5_pulse_end", refundValid, 0);
    checkOutput("tp5_refund_hold", refundB, 2);

    // Reset mid-ISSUE, then confirm with number 0
    insertCoin(2'd0, 2'b00);
    confirmReq(2'b10);
    checkOutput("tp6_issue_busy", busy, 1);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("tp6_reset_busy", busy, 0);
    checkOutput("tp6_reset_num", reqItemNumber, 0);
    checkOutput("tp6_reset_total", totalValue, 0);
    confirmReq(2'b10);
    checkOutput("tp6_zero_confirm", busy, 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic rst, cv, sv, sf, cf, cn;
      logic [1:0] ct, st, svc;
      logic [2:0] sn;
      rst = ($urandom_range(0, 199) == 0);
      cv  = ($urandom_range(0, 99) < ((n < 2000) ? 85 : 40));
      ct  = 2'($urandom_range(0, 3));
      sv  = ($urandom_range(0, 9) == 0);
      st  = 2'($urandom_range(0, 3));
      sn  = 3'($urandom_range(0, 7));
      sf  = 1'($urandom_range(0, 1));
      cf  = ($urandom_range(0, 9) == 0);
      cn  = ($urandom_range(0, 99) < ((n < 2000) ? 1 : 6));
      svc = 2'($urandom_range(0, 3));
      applyStimulus(rst, cv, ct, sv, st, sn, sf, cf, cn, svc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coin_request_collector.md
Name: coin_request_collector

Overview:
- Upstream front-end for vendingMachine. Accumulates single coin insertions and one item selection over many cycles.
- On a confirm pulse, presents one aggregated request on vendingMachine's coinInA..D / itemTypeIn / itemNumberIn / forceIn, handshaking against serviceTypeOut.
- Supports cancel/refund of held coins. Blocks new input while a transaction is in flight.

Parameters:
- MAX_COUNT, 63: per-type coin cap (1..63); further coins of that type are rejected.

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- coinValid  input  1  one coin inserted this cycle
- coinType  input  2  00=A(50), 01=B(10), 10=C(5), 11=D(1)
- selValid  input  1  latch selType/selNumber/selForce
- selType  input  2  item type 00..11
- selNumber  input  3  item quantity
- selForce  input  1  force-service flag
- confirm  input  1  issue request
- cancel  input  1  refund held coins
- serviceTypeIn  input  2  from vendingMachine serviceTypeOut (00 OFF, 01 ON, 10 BUSY)
- reqCoinA/B/C/D  output  6 each  to coinInA..D
- reqItemType  output  2  to itemTypeIn
- reqItemNumber  output  3  to itemNumberIn; nonzero only in ISSUE
- reqForce  output  1  to forceIn
- coinReject  output  1  pulse: inserted coin not accepted
- refundValid  output  1  pulse: refundA..D valid
- refundA/B/C/D  output  6 each  refunded coin counts
- totalValue  output  13  50*cntA+10*cntB+5*cntC+cntD
- busy  output  1  state != IDLE

Behaviour:
- Reset (reset=1 at posedge): state=IDLE. All counters, latched selection, req*, refund*, coinReject, refundValid = 0. Reset has priority in every state, including mid-ISSUE or WAIT_DONE.
- All outputs are registered except totalValue and busy, which are combinational from registers. totalValue max is 63*66 = 4158, computed in 13 bits with no overflow.
- IDLE:
  - coinValid: increment the matching counter if below MAX_COUNT; else coinReject=1 next cycle and the counter is unchanged.
  - selValid: overwrite latched type/number/force.
  - cancel (priority over confirm): refundA..D = counters, including a same-cycle accepted coin. refundValid pulses 1 cycle. Counters clear. Selection is kept.
  - confirm with latched number != 0 and no cancel: req* loaded from counters (including a same-cycle coin) and selection (including a same-cycle selValid). Go to ISSUE.
  - confirm with latched number == 0: ignored.
- ISSUE: req* held stable.
  - At a posedge where serviceTypeIn == 01: vendingMachine samples the request on this same edge. Zero all req*, clear counters and selection, go to WAIT_DONE.
  - Otherwise hold indefinitely.
- WAIT_DONE:
  - serviceTypeIn == 00 (OFF) -> IDLE.
  - Any other value: stay.
- In ISSUE and WAIT_DONE: coinValid causes a coinReject pulse and the coin is not counted. selValid, confirm and cancel are ignored.
- refundValid and coinReject are single-cycle pulses. refund* hold their last value otherwise.

Test Plan:
- Reset, then insert A,A,B,D,D one per cycle -> cntA=2, cntB=1, cntD=2, totalValue=112. All req* remain 0.
- From above, selValid type=01 number=3 force=0, confirm with serviceTypeIn=01 -> ISSUE with reqCoinA=2, reqCoinB=1, reqCoinD=2, reqItemNumber=3. Next edge -> req* 0, busy=1. serviceTypeIn 10 then 00 -> IDLE, busy=0.
- confirm while serviceTypeIn=10 for 4 cycles -> request held unchanged. Serves on the first edge with 01.
- Insert 64 type-C coins with MAX_COUNT=63 -> cntC=63, one coinReject pulse on the 64th. A coin during WAIT_DONE -> coinReject, count unchanged.
- Hold 2 B coins, then cancel+confirm+coinValid(D) in the same cycle -> refundB=2, refundD=1, refundValid 1 cycle, counters 0, stays IDLE.
- Assert reset during ISSUE -> next cycle IDLE, reqItemNumber=0, all counters 0. confirm with number 0 -> no transition.
